// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO: register word addresses and STATUS bit positions.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd3;
    localparam logic [2:0] ADDR_OUTCLR = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/avalon_led_pio_blink_if.sv
// Avalon-MM slave signals for the LED PIO. The master modport is the CPU/bus side
// and the slave modport is the PIO side.
interface avalon_led_pio_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/blink_prescaler.sv
// Blink prescaler: counts 0..period, toggling phase on each wrap.
// Phase is held at 1 while period is 0, so blinking LEDs stay lit.
// A reload (PERIOD write) restarts the count and forces phase high on the same edge.
// The '>=' compare guarantees a wrap if period is lowered below the current count.
// phase_next is exported so the top can register out_port from this edge's values.
module blink_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                reload,
    output logic                phase,
    output logic                phase_next
);

    logic [PERIOD_W-1:0] r_count;
    logic                r_phase;
    logic [PERIOD_W-1:0] w_count_next;

    // Next count and phase: reload wins, then the idle hold, then the normal step.
    always_comb begin
        w_count_next = r_count;
        phase_next   = r_phase;
        if (reload || (period == '0)) begin
            w_count_next = '0;
            phase_next   = 1'b1;
        end else if (r_count >= period) begin
            w_count_next = '0;
            phase_next   = ~r_phase;
        end else begin
            w_count_next = r_count + 1'b1;
        end
    end

    // Count and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_phase <= phase_next;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM LED output PIO with atomic set/clear, per-bit blink enable and a
// programmable blink half-period. Zero-wait-state slave; reads have no side effects.
module avalon_led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               PERIOD_W   = 24,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    avalon_led_pio_blink_if.slave        bus,
    output logic [WIDTH-1:0]             out_port
);

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blink;
    logic [PERIOD_W-1:0] r_period;
    logic [WIDTH-1:0]    r_out;

    logic                w_wr;
    logic [WIDTH-1:0]    w_data_next;
    logic [WIDTH-1:0]    w_blink_next;
    logic [PERIOD_W-1:0] w_period_next;
    logic                w_reload;
    logic                w_phase;
    logic                w_phase_next;
    logic [WIDTH-1:0]    w_out_next;
    logic                w_unused;

    assign w_wr     = bus.chipselect & ~bus.write_n;
    // Only the low WIDTH / PERIOD_W bits of writedata are meaningful.
    assign w_unused = ^bus.writedata;

    // Register write decode; at most one register changes per cycle.
    always_comb begin
        w_data_next   = r_data;
        w_blink_next  = r_blink;
        w_period_next = r_period;
        w_reload      = 1'b0;
        if (w_wr) begin
            case (bus.address)
                ADDR_DATA:   w_data_next  = bus.writedata[WIDTH-1:0];
                ADDR_BLINK:  w_blink_next = bus.writedata[WIDTH-1:0];
                ADDR_PERIOD: begin
                    w_period_next = bus.writedata[PERIOD_W-1:0];
                    w_reload      = 1'b1;
                end
                ADDR_OUTSET: w_data_next  = r_data | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLR: w_data_next  = r_data & ~bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    blink_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .period     (r_period),
        .reload     (w_reload),
        .phase      (w_phase),
        .phase_next (w_phase_next)
    );

    // Blinking bits are gated by the phase that will be in force after this edge.
    assign w_out_next = w_data_next & (~w_blink_next | {WIDTH{w_phase_next}});

    // Register file and LED output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= RESET_DATA;
            r_blink  <= '0;
            r_period <= '0;
            r_out    <= RESET_DATA;
        end else begin
            r_data   <= w_data_next;
            r_blink  <= w_blink_next;
            r_period <= w_period_next;
            r_out    <= w_out_next;
        end
    end

    assign out_port = r_out;

    // Combinational read mux, zero-extended; write-only and unused addresses read 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata[WIDTH-1:0]    = r_data;
            ADDR_BLINK:  bus.readdata[WIDTH-1:0]    = r_blink;
            ADDR_PERIOD: bus.readdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: bus.readdata[STATUS_PHASE_BIT] = w_phase;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Self-checking bench for avalon_led_pio_blink (WIDTH=10, RESET_DATA=10'h155).
// Expected values are pushed to a scoreboard queue as stimulus is applied and
// popped when the corresponding DUT output is sampled on the falling edge.
module tb_avalon_led_pio_blink;
    import led_pio_pkg::*;

    logic       clk;
    logic       reset;
    logic [9:0] out_port;

    avalon_led_pio_blink_if bus_if ();

    avalon_led_pio_blink #(
        .WIDTH      (10),
        .PERIOD_W   (24),
        .RESET_DATA (10'h155)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [9:0] e);
        sb_push(tag, {22'b0, e});
        sb_pop_check({22'b0, out_port});
    endtask

    task automatic expect_rd(input logic [2:0] a, input string tag, input logic [31:0] e);
        sb_push(tag, e);
        bus_if.address = a;
        #1;
        sb_pop_check(bus_if.readdata);
    endtask

    // Drive one write cycle; returns on the falling edge after the write edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'hDEAD_BEEF;
    endtask

    task automatic check_reset_state(input string pfx);
        expect_out({pfx, "_out"}, 10'h155);
        expect_rd(ADDR_DATA,   {pfx, "_data"},   32'h155);
        expect_rd(ADDR_BLINK,  {pfx, "_blink"},  32'h0);
        expect_rd(ADDR_PERIOD, {pfx, "_period"}, 32'h0);
        expect_rd(ADDR_STATUS, {pfx, "_status"}, 32'h1);
    endtask

    logic exp_ph;

    initial begin
        reset             = 1'b1;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_reset_state("t1");

        // Write, set and clear
        bus_write(ADDR_DATA,   32'h0F0);
        bus_write(ADDR_OUTSET, 32'hFFFF_F003);
        bus_write(ADDR_OUTCLR, 32'h010);
        expect_rd(ADDR_DATA, "t2_data", 32'h0E3);
        expect_rd(ADDR_OUTSET, "t2_rd_outset", 32'h0);
        expect_out("t2_out", 10'h0E3);

        // Blink bit 0 with half-period 4
        bus_write(ADDR_DATA,   32'h3FF);
        bus_write(ADDR_BLINK,  32'h001);
        bus_write(ADDR_PERIOD, 32'd3);
        expect_rd(ADDR_PERIOD, "t3_period", 32'd3);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_ph = (((k / 4) % 2) == 0);
            expect_out("t3_out", {9'h1FF, exp_ph});
            expect_rd(ADDR_STATUS, "t3_status", {31'b0, exp_ph});
        end

        // Lowering PERIOD mid-count restarts the phase
        bus_write(ADDR_PERIOD, 32'd100);
        repeat (60) @(negedge clk);
        expect_rd(ADDR_STATUS, "t4_status_mid", 32'h1);
        bus_write(ADDR_PERIOD, 32'd10);
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) @(negedge clk);
            exp_ph = (k < 11);
            expect_rd(ADDR_STATUS, "t4_status", {31'b0, exp_ph});
            expect_out("t4_out", {9'h1FF, exp_ph});
        end

        // PERIOD=0 holds blinking bits on; unused addresses read 0
        bus_write(ADDR_PERIOD, 32'd0);
        bus_write(ADDR_BLINK,  32'h3FF);
        bus_write(ADDR_DATA,   32'h2AA);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expect_out("t5_out", 10'h2AA);
        end
        expect_rd(3'd3, "t5_rd3", 32'h0);
        expect_rd(3'd4, "t5_rd4", 32'h0);
        expect_rd(3'd6, "t5_rd6", 32'h0);
        expect_rd(3'd7, "t5_rd7", 32'h0);
        expect_rd(ADDR_STATUS, "t5_status", 32'h1);
        expect_rd(ADDR_BLINK,  "t5_blink",  32'h3FF);

        // Reset mid-blink with a concurrent DATA write
        bus_write(ADDR_DATA,   32'h3FF);
        bus_write(ADDR_PERIOD, 32'd2);
        repeat (4) @(negedge clk);
        expect_out("t6_pre_out", 10'h000);
        reset             = 1'b1;
        bus_if.address    = ADDR_DATA;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = 32'h3C3;
        @(negedge clk);
        reset             = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        check_reset_state("t6");
        repeat (5) @(negedge clk);
        expect_out("t6_out_later", 10'h155);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
